// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack sequencing and a 2-entry instruction FIFO toward decode.
// Optional stall performance counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ~ADDR_W'(3);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] redirect_q;
  logic [ADDR_W-1:0] target_aligned;

  logic [ADDR_W-1:0] mem_pc_q   [2];
  logic [31:0]       mem_data_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              push;
  logic              pop;

  assign target_aligned = branch_target & ~ADDR_W'(3);

  // A redirect kills both the returning word and any same-cycle pop.
  assign push = (state_q == FETCH) && imem_ack && !branch_taken;
  assign pop  = inst_valid && inst_ready && !branch_taken;

  // NOTE: give every always_comb target a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (branch_taken)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_A;
      redirect_q <= RESET_PC_A;
    end else begin
      case (state_q)
        IDLE: begin
          if (branch_taken)
            pc_q <= target_aligned;
          else if (count_q < 2'd2)
            state_q <= FETCH;
        end
        FETCH: begin
          if (branch_taken && imem_ack) begin
            pc_q    <= target_aligned;
            state_q <= IDLE;
          end else if (branch_taken) begin
            // Address must stay stable until ack, so park the target.
            redirect_q <= target_aligned;
            state_q    <= DROP;
          end else if (imem_ack) begin
            pc_q    <= pc_q + ADDR_W'(4);
            state_q <= (count_d < 2'd2) ? FETCH : IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc_q    <= branch_taken ? target_aligned : redirect_q;
            state_q <= IDLE;
          end else if (branch_taken) begin
            redirect_q <= target_aligned;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (branch_taken) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // NOTE: FIFO storage is not reset; outputs are gated by inst_valid so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= pc_q;
      mem_data_q[wr_ptr_q] <= imem_data;
    end
  end

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_out   = inst_valid ? mem_data_q[rd_ptr_q] : '0;
  assign opcode     = inst_out[31:26];
  assign pc_plus4   = inst_valid ? (mem_pc_q[rd_ptr_q] + ADDR_W'(4)) : '0;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (!inst_valid && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: a second instance with RESET_PC=FFFF_FFFC covers PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        inst_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  logic        imem_req,  imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        inst_valid, inst_valid_w;
  logic [31:0] inst_out, inst_out_w;
  logic [5:0]  opcode, opcode_w;
  logic [31:0] pc_plus4, pc_plus4_w;
  logic [15:0] stall_cnt, stall_cnt_w;

  logic [63:0] sb [$];   // {pc, instruction} in expected decode order
  int n_pass  = 0;
  int n_total = 0;

`ifdef FETCH_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd6;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .opcode(opcode),
    .pc_plus4(pc_plus4), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall_cnt(stall_cnt)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(inst_valid_w),
    .inst_ready(inst_ready), .inst_out(inst_out_w), .opcode(opcode_w),
    .pc_plus4(pc_plus4_w), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall_cnt(stall_cnt_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scores any decode handshake due at the next edge, then advances to the following negedge.
  task automatic cyc();
    logic [63:0] e;
    if (!rst && inst_valid === 1'b1 && inst_ready && !branch_taken) begin
      if (sb.size() == 0) begin
        check("stale_inst", {63'd0, inst_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("inst_out", {32'd0, inst_out}, {32'd0, e[31:0]});
        check("opcode",   {58'd0, opcode},   {58'd0, e[31:26]});
        check("pc_plus4", {32'd0, pc_plus4}, {32'd0, e[63:32] + 32'd4});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] data, input int lat, input logic [31:0] addr);
    int w = 0;
    while (imem_req !== 1'b1 && w < 20) begin
      cyc();
      w++;
    end
    check("req_seen", {63'd0, imem_req}, 64'd1);
    check("req_addr", {32'd0, imem_addr}, {32'd0, addr});
    for (int i = 1; i < lat; i++) begin
      cyc();
      check("addr_stable", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, addr});
    end
    imem_ack  = 1'b1;
    imem_data = data;
    sb.push_back({addr, data});
    cyc();
    imem_ack  = 1'b0;
    imem_data = '0;
  endtask

  task automatic do_reset(input logic ack_during);
    rst = 1'b1;
    imem_ack = ack_during;
    branch_taken = 1'b0;
    inst_ready = 1'b0;
    sb.delete();
    cyc();
    cyc();
    rst = 1'b0;
    imem_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // Reset values with ack held high, then counter and wrap on the first fetch.
    rst = 1'b1;
    imem_ack = 1'b1;
    cyc();
    cyc();
    check("rst_req",      {63'd0, imem_req},   64'd0);
    check("rst_valid",    {63'd0, inst_valid}, 64'd0);
    check("rst_stall",    {48'd0, stall_cnt},  64'd0);
    check("rst_inst_out", {32'd0, inst_out},   64'd0);
    check("rst_opcode",   {58'd0, opcode},     64'd0);
    check("rst_pc_plus4", {32'd0, pc_plus4},   64'd0);
    rst = 1'b0;
    imem_ack = 1'b0;
    cyc();
    check("wrap_first_addr", {32'd0, imem_addr_w}, {32'd0, 32'hFFFF_FFFC});
    fetch(32'h2001_0005, 5, 32'h0);
    check("stall_first_valid", {48'd0, stall_cnt}, {48'd0, EXP_STALL});
    check("first_valid", {63'd0, inst_valid}, 64'd1);
    check("wrap_second_addr", {31'd0, imem_req_w, imem_addr_w}, {31'd0, 1'b1, 32'h0});
    inst_ready = 1'b1;
    cyc();
    check("drained", {63'd0, inst_valid}, 64'd0);

    // Zero-wait streaming.
    do_reset(1'b0);
    inst_ready = 1'b1;
    fetch(32'h0000_0020, 1, 32'h0);
    check("s0_op", {58'd0, opcode}, 64'h00);
    check("s0_p4", {32'd0, pc_plus4}, 64'd4);
    check("s1_req", {63'd0, imem_req}, 64'd1);
    fetch(32'h8C01_0004, 1, 32'h4);
    check("s1_op", {58'd0, opcode}, 64'h23);
    check("s1_p4", {32'd0, pc_plus4}, 64'd8);
    check("s2_req", {63'd0, imem_req}, 64'd1);
    fetch(32'hAC01_0008, 1, 32'h8);
    check("s2_op", {58'd0, opcode}, 64'h2B);
    check("s2_p4", {32'd0, pc_plus4}, 64'd12);
    cyc();
    check("stream_empty", {63'd0, inst_valid}, 64'd0);

    // Backpressure: two entries then request stops.
    do_reset(1'b0);
    fetch(32'h1111_0000, 3, 32'h0);
    fetch(32'h2222_0004, 3, 32'h4);
    check("bp_req_off", {63'd0, imem_req}, 64'd0);
    check("bp_valid",   {63'd0, inst_valid}, 64'd1);
    cyc();
    cyc();
    check("bp_req_still_off", {63'd0, imem_req}, 64'd0);
    inst_ready = 1'b1;
    fetch(32'h3333_0008, 1, 32'h8);
    cyc();
    cyc();
    check("bp_sb_empty", {63'd0, inst_valid}, 64'd0);

    // Redirect while a request is in flight.
    do_reset(1'b0);
    fetch(32'h4444_0000, 1, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    sb.delete();
    cyc();
    branch_taken = 1'b0;
    check("drop_hold", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h4});
    check("drop_flushed", {63'd0, inst_valid}, 64'd0);
    cyc();
    check("drop_hold2", {32'd0, imem_addr}, 64'h4);
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    cyc();
    imem_ack  = 1'b0;
    check("drop_discard", {63'd0, inst_valid}, 64'd0);
    fetch(32'h5555_0100, 1, 32'h100);

    // Redirect coincident with pop and ack: head and returning word both die.
    inst_ready    = 1'b1;
    imem_ack      = 1'b1;
    imem_data     = 32'h6666_0104;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0040;
    sb.delete();
    cyc();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    check("coinc_empty", {63'd0, inst_valid}, 64'd0);
    check("coinc_req",   {63'd0, imem_req},   64'd0);
    fetch(32'h7777_0040, 1, 32'h40);
    cyc();
    cyc();
    check("coinc_drained", {63'd0, inst_valid}, 64'd0);

    // Two redirects back to back; second coincides with the dropped ack.
    check("pre_dbl_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h44});
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    cyc();
    check("dbl_drop_addr", {32'd0, imem_addr}, 64'h44);
    branch_target = 32'h0000_0501;
    imem_ack      = 1'b1;
    cyc();
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    check("dbl_idle", {63'd0, imem_req}, 64'd0);
    fetch(32'h8888_0500, 1, 32'h500);
    cyc();
    cyc();
    check("final_empty", {63'd0, inst_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
